// File: rtl/comp_pkg.sv
// Shared encodings for the comparator event unit: zone codes and debounce candidate direction.
package comp_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_MID  = 2'b00;
    localparam logic [STATE_W-1:0] ST_LOW  = 2'b01;
    localparam logic [STATE_W-1:0] ST_HIGH = 2'b10;

    // Direction the MID-zone debounce run is currently counting towards
    typedef enum logic [1:0] {
        CAND_NONE = 2'b00,
        CAND_LOW  = 2'b01,
        CAND_HIGH = 2'b10
    } cand_e;

    // Zone entered when a candidate run completes
    function automatic logic [STATE_W-1:0] cand_to_state(input cand_e c);
        logic [STATE_W-1:0] s;
        s = ST_MID;
        if (c == CAND_LOW) begin
            s = ST_LOW;
        end else if (c == CAND_HIGH) begin
            s = ST_HIGH;
        end
        return s;
    endfunction

endpackage

// File: rtl/comp_dbnc.sv
// Consecutive-sample debounce counter: restart/increment/clear controls, saturating,
// reports when the sample being accepted this cycle completes the run.
module comp_dbnc #(
    parameter int unsigned DBNC_W = 4
) (
    input  logic              SYSCLK,
    input  logic              SYSRSTn,
    input  logic              inc,
    input  logic              restart,
    input  logic              clear,
    input  logic [DBNC_W-1:0] dbnc,
    output logic              reached_c
);

    localparam logic [DBNC_W-1:0] CNT_MAX = '1;
    localparam logic [DBNC_W-1:0] CNT_ONE = DBNC_W'(1);

    logic [DBNC_W-1:0] cnt;
    logic [DBNC_W-1:0] cnt_nxt_c;
    logic [DBNC_W-1:0] thr_c;

    // Next count for an accepted sample and run-complete detection (0 programmed acts as 1)
    always_comb begin
        thr_c     = (dbnc == '0) ? CNT_ONE : dbnc;
        cnt_nxt_c = cnt;
        if (restart) begin
            cnt_nxt_c = CNT_ONE;
        end else if (inc) begin
            cnt_nxt_c = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
        end
        reached_c = (restart || inc) && (cnt_nxt_c >= thr_c);
    end

    // Count register; clear wins so a completed run starts the next zone from zero
    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/comp_event_unit.sv
// Comparator threshold stage: classifies valid samples into LOW/MID/HIGH zones with
// hysteresis and debounce, producing registered levels, event pulses and sticky flags.
module comp_event_unit
    import comp_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DBNC_W = 4
) (
    input  logic              SYSCLK,
    input  logic              SYSRSTn,
    input  logic              comp_en_reg,
    input  logic              comp_signed_reg,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] comp_ltrd_reg,
    input  logic [DATA_W-1:0] comp_htrd_reg,
    input  logic [DATA_W-1:0] comp_hyst_reg,
    input  logic [DBNC_W-1:0] comp_dbnc_reg,
    input  logic              comp_low_clr,
    input  logic              comp_high_clr,
    output logic [1:0]        comp_state,
    output logic              comp_low_signal,
    output logic              comp_high_signal,
    output logic              comp_event,
    output logic              comp_low_flag,
    output logic              comp_high_flag
);

    // Two guard bits keep ltrd+hyst and htrd-hyst exact for either signedness
    localparam int unsigned EXT_W = DATA_W + 2;

    logic signed [EXT_W-1:0] data_x;
    logic signed [EXT_W-1:0] ltrd_x;
    logic signed [EXT_W-1:0] htrd_x;
    logic signed [EXT_W-1:0] hyst_x;
    logic signed [EXT_W-1:0] exit_lo_thr;
    logic signed [EXT_W-1:0] exit_hi_thr;

    logic below_c;
    logic above_c;
    logic exit_low_c;
    logic exit_high_c;

    cand_e       cand;
    cand_e       cand_nxt;
    cand_e       dir_c;
    logic [1:0]  state_nxt;

    logic cnt_inc;
    logic cnt_restart;
    logic cnt_clear;
    logic cnt_reached_c;

    // Extend operands per signedness mode; hysteresis is always a magnitude
    always_comb begin
        if (comp_signed_reg) begin
            data_x = {{2{data_in[DATA_W-1]}},       data_in};
            ltrd_x = {{2{comp_ltrd_reg[DATA_W-1]}}, comp_ltrd_reg};
            htrd_x = {{2{comp_htrd_reg[DATA_W-1]}}, comp_htrd_reg};
        end else begin
            data_x = {2'b00, data_in};
            ltrd_x = {2'b00, comp_ltrd_reg};
            htrd_x = {2'b00, comp_htrd_reg};
        end
        hyst_x      = {2'b00, comp_hyst_reg};
        exit_lo_thr = ltrd_x + hyst_x;
        exit_hi_thr = htrd_x - hyst_x;
    end

    // Zone conditions; below takes priority so a crossed threshold pair resolves to LOW
    always_comb begin
        below_c     = data_x <  ltrd_x;
        above_c     = data_x >= htrd_x;
        exit_low_c  = data_x >= exit_lo_thr;
        exit_high_c = data_x <  exit_hi_thr;
        dir_c       = below_c ? CAND_LOW : (above_c ? CAND_HIGH : CAND_NONE);
    end

    // Debounce counter controls for an accepted sample
    always_comb begin
        cnt_inc     = 1'b0;
        cnt_restart = 1'b0;
        if (comp_en_reg && data_valid) begin
            case (comp_state)
                ST_MID: begin
                    if (dir_c != CAND_NONE) begin
                        if (dir_c == cand) begin
                            cnt_inc = 1'b1;
                        end else begin
                            cnt_restart = 1'b1;
                        end
                    end
                end
                ST_LOW:  cnt_inc = exit_low_c;
                ST_HIGH: cnt_inc = exit_high_c;
                default: ;
            endcase
        end
    end

    comp_dbnc #(
        .DBNC_W (DBNC_W)
    ) u_dbnc (
        .SYSCLK    (SYSCLK),
        .SYSRSTn   (SYSRSTn),
        .inc       (cnt_inc),
        .restart   (cnt_restart),
        .clear     (cnt_clear),
        .dbnc      (comp_dbnc_reg),
        .reached_c (cnt_reached_c)
    );

    // Next zone, candidate tracking and counter clears; LOW<->HIGH always passes through MID
    always_comb begin
        state_nxt = comp_state;
        cand_nxt  = cand;
        cnt_clear = 1'b0;
        if (!comp_en_reg) begin
            state_nxt = ST_MID;
            cand_nxt  = CAND_NONE;
            cnt_clear = 1'b1;
        end else if (data_valid) begin
            case (comp_state)
                ST_MID: begin
                    if (dir_c == CAND_NONE) begin
                        cand_nxt  = CAND_NONE;
                        cnt_clear = 1'b1;
                    end else begin
                        cand_nxt = dir_c;
                    end
                    if (cnt_reached_c) begin
                        state_nxt = cand_to_state(dir_c);
                        cand_nxt  = CAND_NONE;
                        cnt_clear = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (!exit_low_c || cnt_reached_c) begin
                        cnt_clear = 1'b1;
                    end
                    if (cnt_reached_c) begin
                        state_nxt = ST_MID;
                    end
                end
                ST_HIGH: begin
                    if (!exit_high_c || cnt_reached_c) begin
                        cnt_clear = 1'b1;
                    end
                    if (cnt_reached_c) begin
                        state_nxt = ST_MID;
                    end
                end
                default: begin
                    state_nxt = ST_MID;
                    cand_nxt  = CAND_NONE;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // Zone register and registered outputs; a set on entry beats a same-cycle clear
    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            comp_state       <= ST_MID;
            cand             <= CAND_NONE;
            comp_low_signal  <= 1'b0;
            comp_high_signal <= 1'b0;
            comp_event       <= 1'b0;
            comp_low_flag    <= 1'b0;
            comp_high_flag   <= 1'b0;
        end else begin
            comp_state       <= state_nxt;
            cand             <= cand_nxt;
            comp_low_signal  <= (state_nxt == ST_LOW);
            comp_high_signal <= (state_nxt == ST_HIGH);
            comp_event       <= comp_en_reg && (state_nxt != comp_state);
            comp_low_flag    <= (comp_en_reg && (state_nxt == ST_LOW) && (comp_state != ST_LOW))
                                || (comp_low_flag && !comp_low_clr);
            comp_high_flag   <= (comp_en_reg && (state_nxt == ST_HIGH) && (comp_state != ST_HIGH))
                                || (comp_high_flag && !comp_high_clr);
        end
    end

endmodule

// File: tb/tb_comp_event_unit.sv
// Bench for comp_event_unit: directed vector table, hand-written corner sequences,
// then randomized traffic against a zone/run-length reference model.
module tb_comp_event_unit;

    localparam int DATA_W = 32;
    localparam int DBNC_W = 4;

    logic              SYSCLK = 1'b0;
    logic              SYSRSTn;
    logic              comp_en_reg;
    logic              comp_signed_reg;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic [DATA_W-1:0] comp_ltrd_reg;
    logic [DATA_W-1:0] comp_htrd_reg;
    logic [DATA_W-1:0] comp_hyst_reg;
    logic [DBNC_W-1:0] comp_dbnc_reg;
    logic              comp_low_clr;
    logic              comp_high_clr;
    logic [1:0]        comp_state;
    logic              comp_low_signal;
    logic              comp_high_signal;
    logic              comp_event;
    logic              comp_low_flag;
    logic              comp_high_flag;

    comp_event_unit #(.DATA_W(DATA_W), .DBNC_W(DBNC_W)) dut (
        .SYSCLK           (SYSCLK),
        .SYSRSTn          (SYSRSTn),
        .comp_en_reg      (comp_en_reg),
        .comp_signed_reg  (comp_signed_reg),
        .data_in          (data_in),
        .data_valid       (data_valid),
        .comp_ltrd_reg    (comp_ltrd_reg),
        .comp_htrd_reg    (comp_htrd_reg),
        .comp_hyst_reg    (comp_hyst_reg),
        .comp_dbnc_reg    (comp_dbnc_reg),
        .comp_low_clr     (comp_low_clr),
        .comp_high_clr    (comp_high_clr),
        .comp_state       (comp_state),
        .comp_low_signal  (comp_low_signal),
        .comp_high_signal (comp_high_signal),
        .comp_event       (comp_event),
        .comp_low_flag    (comp_low_flag),
        .comp_high_flag   (comp_high_flag)
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: zone 0 MID, 1 LOW, 2 HIGH; run length and run direction
    int m_zone, m_cnt, m_dir;
    bit m_ev, m_lf, m_hf;

    function automatic longint to_num(input logic [DATA_W-1:0] v, input bit s);
        if (s) return longint'($signed(v));
        return longint'({32'h0, v});
    endfunction

    task automatic model_reset();
        m_zone = 0; m_cnt = 0; m_dir = 0;
        m_ev = 0; m_lf = 0; m_hf = 0;
    endtask

    task automatic model_step();
        longint d, lt, ht, hy;
        int thr, nz, dir;
        bit below, above, exl, exh;
        if (!comp_en_reg) begin
            m_zone = 0; m_cnt = 0; m_dir = 0; m_ev = 0;
            m_lf = m_lf && !comp_low_clr;
            m_hf = m_hf && !comp_high_clr;
            return;
        end
        nz = m_zone;
        if (data_valid) begin
            d  = to_num(data_in, comp_signed_reg);
            lt = to_num(comp_ltrd_reg, comp_signed_reg);
            ht = to_num(comp_htrd_reg, comp_signed_reg);
            hy = to_num(comp_hyst_reg, 1'b0);
            below = d < lt;
            above = d >= ht;
            exl   = d >= lt + hy;
            exh   = d < ht - hy;
            thr   = (comp_dbnc_reg == 0) ? 1 : int'(comp_dbnc_reg);
            if (m_zone == 0) begin
                dir = below ? 1 : (above ? 2 : 0);
                if (dir == 0) begin
                    m_cnt = 0; m_dir = 0;
                end else if (dir == m_dir) begin
                    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
                end else begin
                    m_cnt = 1; m_dir = dir;
                end
                if (dir != 0 && m_cnt >= thr) begin
                    nz = dir; m_cnt = 0; m_dir = 0;
                end
            end else begin
                if ((m_zone == 1) ? exl : exh) begin
                    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
                    if (m_cnt >= thr) begin
                        nz = 0; m_cnt = 0;
                    end
                end else begin
                    m_cnt = 0;
                end
            end
        end
        m_ev = (nz != m_zone);
        m_lf = (nz == 1 && m_zone != 1) || (m_lf && !comp_low_clr);
        m_hf = (nz == 2 && m_zone != 2) || (m_hf && !comp_high_clr);
        m_zone = nz;
    endtask

    // Advance one clock; model follows the DUT inputs seen at the edge, sample #1 later
    task automatic tick();
        @(posedge SYSCLK);
        if (!SYSRSTn) model_reset();
        else model_step();
        #1;
    endtask

    task automatic smp(input logic [DATA_W-1:0] d, input logic v, input logic lc, input logic hc);
        data_in = d; data_valid = v; comp_low_clr = lc; comp_high_clr = hc;
        tick();
    endtask

    task automatic check(input string name, input logic [1:0] st, input logic ev,
                         input logic lf, input logic hf);
        logic [5:0] act, exp;
        act = {comp_state, comp_low_signal, comp_high_signal, comp_event, comp_low_flag, comp_high_flag};
        exp = {st, st == 2'b01, st == 2'b10, ev, lf, hf};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {state,lo,hi,ev,lf,hf}=%b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_dut();
        data_valid = 0; comp_low_clr = 0; comp_high_clr = 0; data_in = '0;
        SYSRSTn = 1'b0;
        tick();
        tick();
        SYSRSTn = 1'b1;
    endtask

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              valid;
        logic              lclr;
        logic              hclr;
        logic [1:0]        st;
        logic              ev;
        logic              lf;
        logic              hf;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // ltrd=100 htrd=200 hyst=10 dbnc=3 unsigned
        tbl[0]  = '{32'd50,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{32'd50,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{32'd50,  1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{32'd105, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{32'd105, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{32'd105, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{32'd110, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{32'd110, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{32'd110, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{32'd250, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{32'd250, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{32'd150, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{32'd250, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{32'd250, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{32'd250, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1};
        tbl[15] = '{32'd250, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{32'd0,   1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};

        comp_en_reg = 1; comp_signed_reg = 0;
        comp_ltrd_reg = 32'd100; comp_htrd_reg = 32'd200; comp_hyst_reg = 32'd10; comp_dbnc_reg = 4'd3;
        reset_dut();
        check("reset_state", 2'b00, 0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            smp(tbl[i].data, tbl[i].valid, tbl[i].lclr, tbl[i].hclr);
            check($sformatf("table[%0d]", i), tbl[i].st, tbl[i].ev, tbl[i].lf, tbl[i].hf);
        end

        // Signed vs unsigned interpretation of the same bits
        comp_signed_reg = 1; comp_ltrd_reg = 32'hFFFF_FFFB; comp_htrd_reg = 32'd5;
        comp_hyst_reg = 32'd0; comp_dbnc_reg = 4'd1;
        reset_dut();
        smp(32'hFFFF_FFF0, 1, 0, 0);
        check("signed_neg16_low", 2'b01, 1, 1, 0);
        reset_dut();
        smp(32'hFFFF_FFFC, 1, 0, 0);
        check("signed_neg4_mid", 2'b00, 0, 0, 0);
        comp_signed_reg = 0;
        smp(32'hFFFF_FFFC, 1, 0, 0);
        check("unsigned_big_high", 2'b10, 1, 0, 1);
        reset_dut();
        smp(32'hFFFF_FFF0, 1, 0, 0);
        check("unsigned_below_wins", 2'b01, 1, 1, 0);

        // Threshold extremes and htrd-hyst underflow
        comp_ltrd_reg = 32'd0; comp_htrd_reg = 32'hFFFF_FFFF; comp_hyst_reg = 32'd0; comp_dbnc_reg = 4'd1;
        reset_dut();
        smp(32'd0, 1, 0, 0);
        check("zero_not_below", 2'b00, 0, 0, 0);
        smp(32'hFFFF_FFFF, 1, 0, 0);
        check("max_is_above", 2'b10, 1, 0, 1);
        comp_htrd_reg = 32'd3; comp_hyst_reg = 32'd10;
        for (int i = 0; i < 3; i++) smp(32'd0, 1, 0, 0);
        check("hyst_underflow_hold", 2'b10, 0, 0, 1);

        // Sticky set beats clear, clear alone takes effect
        comp_ltrd_reg = 32'd100; comp_htrd_reg = 32'd200; comp_hyst_reg = 32'd10; comp_dbnc_reg = 4'd1;
        reset_dut();
        smp(32'd250, 1, 0, 1);
        check("set_beats_clr", 2'b10, 1, 0, 1);
        smp(32'd250, 0, 0, 1);
        check("clr_next_cycle", 2'b10, 0, 0, 0);

        // Exit HIGH, enter LOW, disable, dbnc=0 acts as 1
        smp(32'd110, 1, 0, 0);
        check("high_exit", 2'b00, 1, 0, 0);
        smp(32'd50, 1, 0, 0);
        check("enter_low", 2'b01, 1, 1, 0);
        comp_en_reg = 0;
        smp(32'd50, 0, 0, 0);
        check("disable_mid_no_event", 2'b00, 0, 1, 0);
        comp_en_reg = 1; comp_dbnc_reg = 4'd0;
        smp(32'd50, 1, 0, 0);
        check("dbnc0_as_one", 2'b01, 1, 1, 0);

        // Async reset mid-count clears run and candidate
        comp_dbnc_reg = 4'd3;
        for (int i = 0; i < 3; i++) smp(32'd110, 1, 0, 0);
        check("low_exit_dbnc3", 2'b00, 1, 1, 0);
        smp(32'd50, 1, 0, 0);
        smp(32'd50, 1, 0, 0);
        check("mid_count_2", 2'b00, 0, 1, 0);
        SYSRSTn = 1'b0;
        #2;
        check("async_reset", 2'b00, 0, 0, 0);
        data_valid = 0;
        tick();
        SYSRSTn = 1'b1;
        smp(32'd50, 1, 0, 0);
        check("count_cleared", 2'b00, 0, 0, 0);

        // Randomized traffic against the model
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                comp_signed_reg = 1'($urandom_range(0, 1));
                comp_ltrd_reg   = 32'($urandom_range(0, 400)) - 32'd200;
                comp_htrd_reg   = comp_ltrd_reg + 32'($urandom_range(0, 300));
                if ($urandom_range(0, 7) == 0) comp_htrd_reg = comp_ltrd_reg - 32'($urandom_range(1, 50));
                comp_hyst_reg   = 32'($urandom_range(0, 40));
                comp_dbnc_reg   = 4'($urandom_range(0, 5));
            end else if ($urandom_range(0, 99) == 0) begin
                comp_dbnc_reg   = 4'($urandom_range(0, 5));
            end
            comp_en_reg = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 15) == 0)
                data_in = $urandom();
            else if ($urandom_range(0, 1) == 0)
                data_in = comp_ltrd_reg + 32'($urandom_range(0, 80)) - 32'd40;
            else
                data_in = comp_htrd_reg + 32'($urandom_range(0, 80)) - 32'd40;
            data_valid    = ($urandom_range(0, 3) != 0);
            comp_low_clr  = ($urandom_range(0, 7) == 0);
            comp_high_clr = ($urandom_range(0, 7) == 0);
            tick();
            check("random", 2'(m_zone), m_ev, m_lf, m_hf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
